// File: rtl/reg_scoreboard_if.sv
// Issue/writeback/flush bundle between the decode stage and the register
// scoreboard, plus the scoreboard's status outputs.
interface reg_scoreboard_if;
    logic        issue_valid;
    logic [4:0]  issue_rs1;
    logic [4:0]  issue_rs2;
    logic        issue_use_rs1;
    logic        issue_use_rs2;
    logic [4:0]  issue_rd;
    logic        issue_long;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        flush;
    logic        stall;
    logic [31:0] busy_mask;
    logic [5:0]  pending_count;
    logic        wb_err;

    // Pipeline side: presents instructions and writebacks, observes hazards.
    modport master (
        output issue_valid, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
        output issue_rd, issue_long, wb_valid, wb_rd, flush,
        input  stall, busy_mask, pending_count, wb_err
    );

    // Scoreboard side.
    modport slave (
        input  issue_valid, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
        input  issue_rd, issue_long, wb_valid, wb_rd, flush,
        output stall, busy_mask, pending_count, wb_err
    );
endinterface

// File: rtl/reg_scoreboard.sv
// Register scoreboard for long-latency writes (div/mul/load-miss).
// Tracks one pending bit per architectural register, stalls issue on
// RAW/WAW hazards or when the in-flight limit is reached, and flags
// writebacks that arrive for registers that are not pending.
module reg_scoreboard #(
    parameter int MAX_PENDING = 4
) (
    input logic            clk,
    input logic            rst_n,
    reg_scoreboard_if.slave sb
);
    localparam logic [5:0] CNT_MAX = 6'(MAX_PENDING);

    logic [31:0] busy_q;
    logic [5:0]  count_q;
    logic        err_q;

    logic [31:0] wb_vec;
    logic [31:0] eff_busy;
    logic [31:0] set_vec;
    logic [31:0] clr_vec;
    logic        wb_hit;
    logic        raw1;
    logic        raw2;
    logic        waw;
    logic        full;
    logic        stall_c;
    logic        set_en;
    logic        clr_en;
    logic        err_en;

    // Hazard detection and next-state enables; a writeback in this cycle
    // releases its register for the stall check since it can be forwarded.
    always_comb begin
        wb_vec = '0;
        if (sb.wb_valid) begin
            wb_vec[sb.wb_rd] = 1'b1;
        end
        eff_busy = busy_q & ~wb_vec;
        wb_hit   = sb.wb_valid && (sb.wb_rd != 5'd0) && busy_q[sb.wb_rd];

        raw1 = sb.issue_use_rs1 && eff_busy[sb.issue_rs1];
        raw2 = sb.issue_use_rs2 && eff_busy[sb.issue_rs2];
        waw  = (sb.issue_rd != 5'd0) && eff_busy[sb.issue_rd];
        full = sb.issue_long && (sb.issue_rd != 5'd0) &&
               (count_q == CNT_MAX) && !wb_hit;

        stall_c = sb.issue_valid && !sb.flush && (raw1 || raw2 || waw || full);

        set_en = sb.issue_valid && !stall_c && sb.issue_long &&
                 (sb.issue_rd != 5'd0);
        clr_en = wb_hit;
        err_en = !sb.flush && sb.wb_valid && (sb.wb_rd != 5'd0) &&
                 !busy_q[sb.wb_rd];

        set_vec = '0;
        if (set_en) begin
            set_vec[sb.issue_rd] = 1'b1;
        end
        clr_vec = clr_en ? wb_vec : 32'd0;
    end

    // Pending mask and its running population count; flush wipes both,
    // and a set on the register being cleared keeps it busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q  <= '0;
            count_q <= '0;
        end else if (sb.flush) begin
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            if (set_en || clr_en) begin
                busy_q <= (busy_q & ~clr_vec) | set_vec;
            end
            if (set_en && !clr_en) begin
                count_q <= count_q + 6'd1;
            end else if (!set_en && clr_en) begin
                count_q <= count_q - 6'd1;
            end
        end
    end

    // Sticky error for writebacks to registers with nothing outstanding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (err_en) begin
            err_q <= 1'b1;
        end
    end

    assign sb.stall         = stall_c;
    assign sb.busy_mask     = busy_q;
    assign sb.pending_count = count_q;
    assign sb.wb_err        = err_q;
endmodule
